sync_fifo_ctrl: RTL and testbench

- Single-clock FIFO controller that drives one dualport_mem instance as a show-ahead synchronous FIFO.
- Owns the write/read pointers, the occupancy count, the status flags and the error flags.
- Generates the memory write strobe and both memory addresses; memory read data passes straight through to the consumer.
- Used wherever producer and consumer share w_clk, in place of the async pointer-synchroniser path.

---
 rtl/sync_fifo_ctrl.sv | 96 +++++++++
 tb/tb_sync_fifo_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl
// Single-clock controller that runs an external dualport_mem as a show-ahead FIFO.
// Owns the read/write pointers, occupancy, status flags and sticky error flags.
//
// Ports
//   w_clk, w_rst              clock, synchronous active-high reset
//   push, push_data           producer request and word to enqueue
//   pop, pop_data             consumer request; head word (valid while !empty)
//   full, empty               registered occupancy flags
//   almost_full, almost_empty registered threshold flags
//   count                     occupancy 0..DEPTH
//   overflow, underflow       sticky error flags, cleared by clr_err
//   clr_err                   error flag clear
//   mem_w_en/addr/data        memory write port
//   mem_r_addr, mem_r_data    memory read port (combinational read)
module sync_fifo_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned AF_THRESH  = DEPTH - 2,
   parameter int unsigned AE_THRESH  = 2
) (
   input  logic                       w_clk,
   input  logic                       w_rst,
   input  logic                       push,
   input  logic [DATA_WIDTH-1:0]      push_data,
   input  logic                       pop,
   output logic [DATA_WIDTH-1:0]      pop_data,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow,
   input  logic                       clr_err,
   output logic                       mem_w_en,
   output logic [$clog2(DEPTH)-1:0]   mem_w_addr,
   output logic [DATA_WIDTH-1:0]      mem_w_data,
   output logic [$clog2(DEPTH)-1:0]   mem_r_addr,
   input  logic [DATA_WIDTH-1:0]      mem_r_data
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [PW-1:0] wptr_nxt;
   logic [PW-1:0] rptr_nxt;
   logic [PW-1:0] cnt_nxt;
   logic          push_acc_c;
   logic          pop_acc_c;

   // Accept decisions use the registered flags of the current cycle.
   always_comb begin
      push_acc_c = push & ~full;
      pop_acc_c  = pop & ~empty;
      wptr_nxt   = wptr + PW'(push_acc_c);
      rptr_nxt   = rptr + PW'(pop_acc_c);
      cnt_nxt    = wptr_nxt - rptr_nxt;
   end

   // Memory interface; read data passes straight through for zero-latency show-ahead.
   assign mem_w_en   = push_acc_c & ~w_rst;
   assign mem_w_addr = wptr[AW-1:0];
   assign mem_w_data = push_data;
   assign mem_r_addr = rptr[AW-1:0];
   assign pop_data   = mem_r_data;
   assign count      = wptr - rptr;

   // Pointer, flag and error state; flags are precomputed from the next count.
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         wptr         <= '0;
         rptr         <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         wptr         <= wptr_nxt;
         rptr         <= rptr_nxt;
         full         <= (cnt_nxt == PW'(DEPTH));
         empty        <= (cnt_nxt == '0);
         almost_full  <= (cnt_nxt >= PW'(AF_THRESH));
         almost_empty <= (cnt_nxt <= PW'(AE_THRESH));
         // A new error in the same cycle as clr_err takes priority.
         overflow     <= (push & full) | (overflow & ~clr_err);
         underflow    <= (pop & empty) | (underflow & ~clr_err);
      end
   end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl with a scoreboard queue for popped data.
module tb_sync_fifo_ctrl;

   logic       w_clk;
   logic       w_rst;
   logic       push;
   logic [7:0] push_data;
   logic       pop;
   logic [7:0] pop_data;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;
   logic       clr_err;
   logic       mem_w_en;
   logic [3:0] mem_w_addr;
   logic [7:0] mem_w_data;
   logic [3:0] mem_r_addr;
   logic [7:0] mem_r_data;

   logic [7:0] mem [16];

   int         n_vec  = 0;
   int         n_miss = 0;

   logic [7:0] exp_q[$];
   int         m_cnt = 0;
   logic [3:0] m_w   = 4'd0;
   logic [3:0] m_r   = 4'd0;
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;

   sync_fifo_ctrl #(
      .DATA_WIDTH (8),
      .DEPTH      (16),
      .AF_THRESH  (14),
      .AE_THRESH  (2)
   ) dut (
      .w_clk        (w_clk),
      .w_rst        (w_rst),
      .push         (push),
      .push_data    (push_data),
      .pop          (pop),
      .pop_data     (pop_data),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow),
      .clr_err      (clr_err),
      .mem_w_en     (mem_w_en),
      .mem_w_addr   (mem_w_addr),
      .mem_w_data   (mem_w_data),
      .mem_r_addr   (mem_r_addr),
      .mem_r_data   (mem_r_data)
   );

   // Behavioural dualport_mem: synchronous write, combinational read.
   always @(posedge w_clk) begin
      if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
   end
   assign mem_r_data = mem[mem_r_addr];

   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   task automatic chk(input string name, input int act, input int exp);
      n_vec = n_vec + 1;
      if (act != exp) begin
         n_miss = n_miss + 1;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // One clock cycle of stimulus; the reference model advances with it.
   task automatic cyc(input logic p, input logic [7:0] d, input logic q,
                      input logic r, input logic ce);
      logic pacc;
      logic qacc;
      logic ewen;
      push = p; push_data = d; pop = q; w_rst = r; clr_err = ce;
      pacc = p && (m_cnt != 16);
      qacc = q && (m_cnt != 0);
      ewen = pacc && !r;
      @(negedge w_clk);
      chk("mem_w_en", int'(mem_w_en), int'(ewen));
      if (ewen) begin
         chk("mem_w_addr", int'(mem_w_addr), int'(m_w));
         chk("mem_w_data", int'(mem_w_data), int'(d));
      end
      @(posedge w_clk);
      #1;
      if (r) begin
         m_cnt = 0; m_w = 4'd0; m_r = 4'd0; m_ovf = 1'b0; m_unf = 1'b0;
         exp_q.delete();
      end else begin
         m_ovf = (p && (m_cnt == 16)) || (m_ovf && !ce);
         m_unf = (q && (m_cnt == 0)) || (m_unf && !ce);
         if (pacc) begin
            exp_q.push_back(d);
            m_w = m_w + 4'd1;
         end
         if (qacc) m_r = m_r + 4'd1;
         m_cnt = m_cnt + int'(pacc) - int'(qacc);
      end
      push = 1'b0; pop = 1'b0; w_rst = 1'b0; clr_err = 1'b0;
      chk("count",        int'(count),        m_cnt);
      chk("full",         int'(full),         int'(m_cnt == 16));
      chk("empty",        int'(empty),        int'(m_cnt == 0));
      chk("almost_full",  int'(almost_full),  int'(m_cnt >= 14));
      chk("almost_empty", int'(almost_empty), int'(m_cnt <= 2));
      chk("overflow",     int'(overflow),     int'(m_ovf));
      chk("underflow",    int'(underflow),    int'(m_unf));
      chk("mem_r_addr",   int'(mem_r_addr),   int'(m_r));
   endtask

   // Monitor: every accepted pop must present the oldest expected word.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge w_clk);
         if (!w_rst && pop && !empty) begin
            n_vec = n_vec + 1;
            if (exp_q.size() == 0) begin
               n_miss = n_miss + 1;
               $display("FAIL pop_data: unexpected accepted pop, got 0x%0h expected no data at %0t", pop_data, $time);
            end else begin
               e = exp_q.pop_front();
               if (pop_data !== e) begin
                  n_miss = n_miss + 1;
                  $display("FAIL pop_data: got 0x%0h expected 0x%0h at %0t", pop_data, e, $time);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      w_rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; push_data = 8'h00;
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("reset_empty", int'(empty), 1);
      chk("reset_count", int'(count), 0);

      // Fill: almost_full first rises after the 14th push, full after the 16th.
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
         if (i == 12) chk("af_after_13", int'(almost_full), 0);
         if (i == 13) chk("af_after_14", int'(almost_full), 1);
         if (i == 14) chk("full_after_15", int'(full), 0);
      end
      chk("full_after_16", int'(full), 1);
      chk("count_16", int'(count), 16);

      // Push while full is rejected and flagged.
      cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
      chk("ovf_set", int'(overflow), 1);
      chk("count_still_16", int'(count), 16);
      chk("head_still_00", int'(pop_data), 8'h00);

      // Drain; the monitor checks 0x00..0x0F in order.
      for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("empty_after_drain", int'(empty), 1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("unf_set", int'(underflow), 1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("ovf_cleared", int'(overflow), 0);
      chk("unf_cleared", int'(underflow), 0);

      // Steady push+pop at occupancy 3 across two pointer wraps.
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         cyc(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 1'b0);
         if (i == 39) chk("steady_count_3", int'(count), 3);
      end
      for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("empty_after_steady", int'(empty), 1);

      // Push and pop together while empty: push only, underflow flagged.
      cyc(1'b1, 8'h5C, 1'b1, 1'b0, 1'b0);
      chk("unf_on_empty_pushpop", int'(underflow), 1);
      chk("not_empty_after_5c", int'(empty), 0);
      chk("head_5c", int'(pop_data), 8'h5C);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      chk("unf_cleared_2", int'(underflow), 0);

      // Reset mid-operation with push held high.
      for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
      chk("count_10", int'(count), 10);
      cyc(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
      chk("rst_count_0", int'(count), 0);
      chk("rst_empty", int'(empty), 1);
      cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
      chk("post_rst_head_77", int'(pop_data), 8'h77);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
